// File: rtl/audio_tone_player.sv
// audio_tone_player
// Plays a short fixed melody as a 1-bit square wave for each accepted sound key.
// Note and gap lengths are counted in video frames; pitch is counted in clocks.
//
// Ports:
//   clk           system clock
//   resetN        asynchronous active-low reset
//   startOfFrame  one-clock pulse per video frame
//   sound_key     requested sound (0 stop, 1 shot, 2 enemy dead, 3 player death, 4 victory)
//   key_strobe    qualifies sound_key for one clock
//   audio_out     square-wave audio
//   sound_active  high while a melody plays (notes and gaps)
//   cur_key       key currently playing, 0 when idle
//   note_idx      index of the current note within the melody
module audio_tone_player #(
   parameter int NOTE_FRAMES = 6,
   parameter int GAP_FRAMES  = 1,
   parameter int DIV_SHIFT   = 0
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic [2:0] sound_key,
   input  logic       key_strobe,
   output logic       audio_out,
   output logic       sound_active,
   output logic [2:0] cur_key,
   output logic [1:0] note_idx
);

   typedef enum logic [1:0] {SIDLE, SNOTE, SGAP} state_t;

   localparam logic [15:0] LP_NOTE_LAST = 16'(NOTE_FRAMES - 1);
   localparam logic [15:0] LP_GAP_LAST  = 16'(GAP_FRAMES - 1);

   state_t      r_state;
   logic [15:0] r_pitch_cnt;
   logic [15:0] r_frame_cnt;
   logic        r_audio;
   logic        r_active;
   logic [2:0]  r_key;
   logic [1:0]  r_idx;

   logic [15:0] w_hp;
   logic        w_pitch_wrap;
   logic        w_valid_key;
   logic        w_accept;
   logic        w_stop;

   // Table half-period in clocks, before the simulation speed-up shift.
   function automatic logic [15:0] base_hp(input logic [2:0] key, input logic [1:0] idx);
      case ({key, idx})
         5'b001_00: base_hp = 16'd30000;
         5'b001_01: base_hp = 16'd20000;
         5'b010_00: base_hp = 16'd40000;
         5'b010_01: base_hp = 16'd30000;
         5'b010_10: base_hp = 16'd20000;
         5'b011_00: base_hp = 16'd20000;
         5'b011_01: base_hp = 16'd30000;
         5'b011_10: base_hp = 16'd40000;
         5'b011_11: base_hp = 16'd60000;
         5'b100_00: base_hp = 16'd24000;
         5'b100_01: base_hp = 16'd20000;
         5'b100_10: base_hp = 16'd16000;
         5'b100_11: base_hp = 16'd12000;
         default:   base_hp = 16'd0;
      endcase
   endfunction

   // Shifted half-period, never allowed below one clock.
   function automatic logic [15:0] eff_hp(input logic [2:0] key, input logic [1:0] idx);
      logic [15:0] h;
      h = base_hp(key, idx) >> DIV_SHIFT;
      eff_hp = (h == 16'd0) ? 16'd1 : h;
   endfunction

   function automatic logic [1:0] last_idx(input logic [2:0] key);
      case (key)
         3'd1:    last_idx = 2'd1;
         3'd2:    last_idx = 2'd2;
         3'd3:    last_idx = 2'd3;
         3'd4:    last_idx = 2'd3;
         default: last_idx = 2'd0;
      endcase
   endfunction

   assign w_hp         = eff_hp(r_key, r_idx);
   assign w_pitch_wrap = (r_pitch_cnt == (w_hp - 16'd1));
   assign w_valid_key  = (sound_key != 3'd0) && (sound_key <= 3'd4);
   // Equal key restarts, higher key preempts, lower key is dropped while playing.
   assign w_accept     = key_strobe && w_valid_key && ((r_state == SIDLE) || (sound_key >= r_key));
   assign w_stop       = key_strobe && (sound_key == 3'd0);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state     <= SIDLE;
         r_pitch_cnt <= 16'd0;
         r_frame_cnt <= 16'd0;
         r_audio     <= 1'b0;
         r_active    <= 1'b0;
         r_key       <= 3'd0;
         r_idx       <= 2'd0;
      end else if (w_stop) begin
         r_state     <= SIDLE;
         r_pitch_cnt <= 16'd0;
         r_frame_cnt <= 16'd0;
         r_audio     <= 1'b0;
         r_active    <= 1'b0;
         r_key       <= 3'd0;
         r_idx       <= 2'd0;
      end else if (w_accept) begin
         // A frame pulse in the accept cycle is deliberately not counted.
         r_state     <= SNOTE;
         r_pitch_cnt <= 16'd0;
         r_frame_cnt <= 16'd0;
         r_audio     <= 1'b0;
         r_active    <= 1'b1;
         r_key       <= sound_key;
         r_idx       <= 2'd0;
      end else begin
         case (r_state)
            SNOTE: begin
               if (startOfFrame && (r_frame_cnt == LP_NOTE_LAST)) begin
                  r_state     <= SGAP;
                  r_frame_cnt <= 16'd0;
                  r_pitch_cnt <= 16'd0;
                  r_audio     <= 1'b0;
               end else begin
                  if (startOfFrame) r_frame_cnt <= r_frame_cnt + 16'd1;
                  if (w_pitch_wrap) begin
                     r_pitch_cnt <= 16'd0;
                     r_audio     <= ~r_audio;
                  end else begin
                     r_pitch_cnt <= r_pitch_cnt + 16'd1;
                  end
               end
            end
            SGAP: begin
               r_audio <= 1'b0;
               if (startOfFrame) begin
                  if (r_frame_cnt == LP_GAP_LAST) begin
                     r_frame_cnt <= 16'd0;
                     r_pitch_cnt <= 16'd0;
                     if (r_idx == last_idx(r_key)) begin
                        r_state  <= SIDLE;
                        r_active <= 1'b0;
                        r_key    <= 3'd0;
                        r_idx    <= 2'd0;
                     end else begin
                        r_state <= SNOTE;
                        r_idx   <= r_idx + 2'd1;
                     end
                  end else begin
                     r_frame_cnt <= r_frame_cnt + 16'd1;
                  end
               end
            end
            default: begin
               r_state <= SIDLE;
            end
         endcase
      end
   end

   assign audio_out    = r_audio;
   assign sound_active = r_active;
   assign cur_key      = r_key;
   assign note_idx     = r_idx;

endmodule

// File: tb/tb_audio_tone_player.sv
// tb_audio_tone_player
// Randomized and directed stimulus for audio_tone_player, checked against a
// behavioural melody model that derives the waveform from elapsed note time.
module tb_audio_tone_player;

   localparam int NF = 6;
   localparam int GF = 1;
   localparam int DS = 10;

   logic       clk = 1'b0;
   logic       resetN;
   logic       startOfFrame;
   logic [2:0] sound_key;
   logic       key_strobe;
   logic       audio_out;
   logic       sound_active;
   logic [2:0] cur_key;
   logic [1:0] note_idx;

   always #5 clk = ~clk;

   audio_tone_player #(
      .NOTE_FRAMES(NF),
      .GAP_FRAMES (GF),
      .DIV_SHIFT  (DS)
   ) dut (
      .clk         (clk),
      .resetN      (resetN),
      .startOfFrame(startOfFrame),
      .sound_key   (sound_key),
      .key_strobe  (key_strobe),
      .audio_out   (audio_out),
      .sound_active(sound_active),
      .cur_key     (cur_key),
      .note_idx    (note_idx)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Melody reference: key, note number, note-or-gap phase, frames seen in the
   // phase and clocks elapsed since the note began sounding.
   int tab [5][4] = '{'{0, 0, 0, 0},
                      '{30000, 20000, 0, 0},
                      '{40000, 30000, 20000, 0},
                      '{20000, 30000, 40000, 60000},
                      '{24000, 20000, 16000, 12000}};
   int ncnt [5] = '{0, 2, 3, 4, 4};
   int m_key, m_idx, m_pulses, m_t;
   bit m_note, m_active;

   function automatic int hp_of(int k, int i);
      int h;
      h = tab[k][i] >> DS;
      return (h < 1) ? 1 : h;
   endfunction

   function automatic logic [6:0] m_vec();
      logic       a;
      logic [2:0] k;
      logic [1:0] ix;
      a = 1'b0;
      if (m_active && m_note) a = ((m_t / hp_of(m_key, m_idx)) % 2) == 1;
      k  = m_key[2:0];
      ix = m_idx[1:0];
      return {a, m_active, k, ix};
   endfunction

   function automatic logic [6:0] dut_vec();
      return {audio_out, sound_active, cur_key, note_idx};
   endfunction

   task automatic model_reset();
      m_key = 0; m_idx = 0; m_pulses = 0; m_t = 0; m_note = 0; m_active = 0;
   endtask

   task automatic model_edge();
      if (!resetN) begin
         model_reset();
      end else if (key_strobe && sound_key == 3'd0) begin
         model_reset();
      end else if (key_strobe && sound_key >= 3'd1 && sound_key <= 3'd4 &&
                   (!m_active || int'(sound_key) >= m_key)) begin
         m_key = int'(sound_key); m_idx = 0; m_note = 1; m_active = 1; m_pulses = 0; m_t = 0;
      end else if (m_active && m_note) begin
         m_t++;
         if (startOfFrame) begin
            m_pulses++;
            if (m_pulses == NF) begin
               m_note = 0; m_pulses = 0;
            end
         end
      end else if (m_active && startOfFrame) begin
         m_pulses++;
         if (m_pulses == GF) begin
            m_pulses = 0;
            if (m_idx == ncnt[m_key] - 1) model_reset();
            else begin
               m_idx++; m_note = 1; m_t = 0;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      int toggles, nonzero;
      logic prev;
      resetN = 1'b0; startOfFrame = 1'b0; sound_key = 3'd0; key_strobe = 1'b0;
      model_reset();
      #1;
      n_total++;
      if (dut_vec() !== 7'd0) $display("FAIL reset_outputs: got %b want %b", dut_vec(), 7'd0);
      else n_pass++;
      tick(); tick();
      resetN = 1'b1;
      toggles = 0; nonzero = 0; prev = audio_out;
      for (int c = 0; c < 1000; c++) begin
         startOfFrame = ($urandom_range(49) == 0);
         tick();
         if (audio_out !== prev) toggles++;
         if (dut_vec() !== 7'd0) nonzero++;
         prev = audio_out;
      end
      startOfFrame = 1'b0;
      n_total++;
      if (toggles != 0) $display("FAIL idle_toggles: got %0d want 0", toggles);
      else n_pass++;
      n_total++;
      if (nonzero != 0) $display("FAIL idle_outputs: got %0d nonzero cycles want 0", nonzero);
      else n_pass++;
   endtask

   task automatic test_key1_melody();
      int pulses, per0, per1, last_rise, last_idx;
      bit done, was_active;
      logic prev;
      sound_key = 3'd1; key_strobe = 1'b1; startOfFrame = 1'b0;
      tick();
      key_strobe = 1'b0;
      n_total++;
      if (dut_vec() !== 7'b0_1_001_00) $display("FAIL key1_accept: got %b want %b", dut_vec(), 7'b0_1_001_00);
      else n_pass++;
      pulses = 0; per0 = -1; per1 = -1; last_rise = -1; last_idx = -1; done = 0;
      prev = audio_out;
      for (int c = 0; c < 5000; c++) begin
         startOfFrame = (c % 200 == 199);
         was_active = sound_active;
         tick();
         if (startOfFrame && was_active) pulses++;
         n_total++;
         if (dut_vec() !== m_vec()) $display("FAIL key1_cycle %0d: got %b want %b", c, dut_vec(), m_vec());
         else n_pass++;
         if (audio_out && !prev) begin
            if (last_rise >= 0 && last_idx == int'(note_idx)) begin
               if (note_idx == 2'd0 && per0 < 0) per0 = c - last_rise;
               if (note_idx == 2'd1 && per1 < 0) per1 = c - last_rise;
            end
            last_rise = c; last_idx = int'(note_idx);
         end
         prev = audio_out;
         if (!sound_active) begin
            done = 1;
            break;
         end
      end
      startOfFrame = 1'b0;
      n_total++;
      if (!done) $display("FAIL key1_timeout: got still active want idle");
      else n_pass++;
      n_total++;
      if (per0 != 58) $display("FAIL key1_period_note0: got %0d want 58", per0);
      else n_pass++;
      n_total++;
      if (per1 != 38) $display("FAIL key1_period_note1: got %0d want 38", per1);
      else n_pass++;
      n_total++;
      if (pulses != 14) $display("FAIL key1_frames: got %0d want 14", pulses);
      else n_pass++;
      n_total++;
      if (cur_key !== 3'd0) $display("FAIL key1_end_key: got %0d want 0", cur_key);
      else n_pass++;
   endtask

   task automatic test_preempt();
      bit reached;
      sound_key = 3'd3; key_strobe = 1'b1; startOfFrame = 1'b0;
      tick();
      key_strobe = 1'b0;
      reached = 0;
      for (int c = 0; c < 3000; c++) begin
         startOfFrame = (c % 50 == 49);
         tick();
         n_total++;
         if (dut_vec() !== m_vec()) $display("FAIL preempt_cycle %0d: got %b want %b", c, dut_vec(), m_vec());
         else n_pass++;
         if (m_active && m_note && m_idx == 2) begin
            reached = 1;
            break;
         end
      end
      startOfFrame = 1'b0;
      n_total++;
      if (!reached) $display("FAIL preempt_timeout: got note %0d want 2", note_idx);
      else n_pass++;
      sound_key = 3'd1; key_strobe = 1'b1;
      tick();
      key_strobe = 1'b0;
      n_total++;
      if ({cur_key, note_idx, sound_active} !== {3'd3, 2'd2, 1'b1})
         $display("FAIL lower_key_dropped: got key %0d idx %0d act %b want key 3 idx 2 act 1",
                  cur_key, note_idx, sound_active);
      else n_pass++;
      tick();
      sound_key = 3'd4; key_strobe = 1'b1;
      tick();
      key_strobe = 1'b0;
      n_total++;
      if ({cur_key, note_idx, audio_out, sound_active} !== {3'd4, 2'd0, 1'b0, 1'b1})
         $display("FAIL higher_key_preempt: got key %0d idx %0d aud %b act %b want key 4 idx 0 aud 0 act 1",
                  cur_key, note_idx, audio_out, sound_active);
      else n_pass++;
   endtask

   task automatic test_stop_and_reserved();
      sound_key = 3'd2; key_strobe = 1'b1; startOfFrame = 1'b0;
      tick();
      key_strobe = 1'b0;
      for (int c = 0; c < 100; c++) tick();
      sound_key = 3'd0; key_strobe = 1'b1;
      tick();
      key_strobe = 1'b0;
      n_total++;
      if (dut_vec() !== 7'd0) $display("FAIL stop_key0: got %b want %b", dut_vec(), 7'd0);
      else n_pass++;
      for (int k = 5; k <= 7; k++) begin
         sound_key = 3'(k); key_strobe = 1'b1; startOfFrame = 1'b1;
         tick();
         key_strobe = 1'b0; startOfFrame = 1'b0;
         tick();
         n_total++;
         if (dut_vec() !== 7'd0) $display("FAIL reserved_key%0d: got %b want %b", k, dut_vec(), 7'd0);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      bit hit;
      sound_key = 3'd1; key_strobe = 1'b1; startOfFrame = 1'b0;
      tick();
      key_strobe = 1'b0;
      hit = 0;
      for (int c = 0; c < 2000; c++) begin
         startOfFrame = (c % 20 == 19);
         if (startOfFrame && m_active && !m_note && m_idx == ncnt[m_key] - 1) begin
            sound_key = 3'd1; key_strobe = 1'b1;
            tick();
            key_strobe = 1'b0; startOfFrame = 1'b0;
            hit = 1;
            n_total++;
            if (dut_vec() !== 7'b0_1_001_00) $display("FAIL back_to_back: got %b want %b", dut_vec(), 7'b0_1_001_00);
            else n_pass++;
            break;
         end
         tick();
         n_total++;
         if (dut_vec() !== m_vec()) $display("FAIL b2b_cycle %0d: got %b want %b", c, dut_vec(), m_vec());
         else n_pass++;
      end
      startOfFrame = 1'b0;
      n_total++;
      if (!hit) $display("FAIL b2b_timeout: got no final gap want final gap");
      else n_pass++;
   endtask

   task automatic test_async_reset();
      bit high;
      sound_key = 3'd4; key_strobe = 1'b1; startOfFrame = 1'b0;
      tick();
      key_strobe = 1'b0;
      high = 0;
      for (int c = 0; c < 2000; c++) begin
         tick();
         if (audio_out) begin
            high = 1;
            break;
         end
      end
      n_total++;
      if (!high) $display("FAIL async_wait_high: got audio 0 want 1");
      else n_pass++;
      #2;
      resetN = 1'b0;
      model_reset();
      #1;
      n_total++;
      if (dut_vec() !== 7'd0) $display("FAIL async_reset_drop: got %b want %b", dut_vec(), 7'd0);
      else n_pass++;
      tick(); tick();
      resetN = 1'b1;
      for (int c = 0; c < 300; c++) begin
         startOfFrame = (c % 50 == 49);
         tick();
         n_total++;
         if (dut_vec() !== 7'd0) $display("FAIL post_reset_idle %0d: got %b want %b", c, dut_vec(), 7'd0);
         else n_pass++;
      end
      startOfFrame = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 20000; c++) begin
         key_strobe   = ($urandom_range(299) == 0);
         sound_key    = 3'($urandom_range(7));
         startOfFrame = ($urandom_range(39) == 0);
         tick();
         n_total++;
         if (dut_vec() !== m_vec()) $display("FAIL random_cycle %0d: got %b want %b", c, dut_vec(), m_vec());
         else n_pass++;
      end
      key_strobe = 1'b0; startOfFrame = 1'b0; sound_key = 3'd0;
   endtask

   initial begin
      test_reset();
      test_key1_melody();
      test_preempt();
      test_stop_and_reserved();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
